// File: rtl/conv_pkg.sv
// Shared types and default sizing for the 3x3 convolution engine.
package conv_pkg;

    localparam int N_TAPS = 9;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 21;
    localparam int SHIFT  = 4;

    localparam int CLAMP_MAX = 255;
    localparam int CLAMP_MIN = 0;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH
    } state_t;

endpackage

// File: rtl/conv_scale_clamp.sv
// Scales the window accumulator by an arithmetic right shift and clamps it
// into the unsigned 8-bit display range, flagging any clamping.
module conv_scale_clamp #(
    parameter int ACC_W = conv_pkg::ACC_W,
    parameter int SHIFT = conv_pkg::SHIFT
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [7:0]       result,
    output logic                    ovf
);
    import conv_pkg::*;

    logic signed [ACC_W-1:0] scaled;

    // Shift, then saturate to CLAMP_MIN..CLAMP_MAX.
    always_comb begin
        scaled = acc >>> SHIFT;
        result = scaled[7:0];
        ovf    = 1'b0;
        if (scaled[ACC_W-1]) begin
            result = 8'(CLAMP_MIN);
            ovf    = 1'b1;
        end else if (scaled[ACC_W-2:8] != '0) begin
            result = 8'(CLAMP_MAX);
            ovf    = 1'b1;
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// Sequential 3x3 convolution engine: one shared multiplier walks the nine
// taps, and the scaled/clamped result is held for the display until the
// next window completes.
module conv3x3_engine #(
    parameter int N_TAPS = conv_pkg::N_TAPS,
    parameter int PIX_W  = conv_pkg::PIX_W,
    parameter int COEF_W = conv_pkg::COEF_W,
    parameter int ACC_W  = conv_pkg::ACC_W,
    parameter int SHIFT  = conv_pkg::SHIFT
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    input  logic              k_we,
    input  logic [3:0]        k_addr,
    input  logic [COEF_W-1:0] k_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        convolution,
    output logic              overflow
);
    import conv_pkg::*;

    localparam int         PROD_W   = PIX_W + COEF_W + 1;
    localparam logic [3:0] LAST_TAP = 4'(N_TAPS - 1);
    localparam logic [3:0] TAP_LIM  = 4'(N_TAPS);

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic        [3:0]         tap;
    logic signed [COEF_W-1:0]  coef [N_TAPS];

    logic signed [PIX_W:0]     pix_s;
    logic signed [PROD_W-1:0]  prod;
    logic                      beat;
    logic                      k_hit;
    logic        [7:0]         clamp_res;
    logic                      clamp_ovf;

    assign beat  = pix_valid & pix_ready;
    assign k_hit = k_we && (state == IDLE) && (k_addr < TAP_LIM);
    assign pix_s = $signed({1'b0, pix_data});
    assign prod  = PROD_W'(pix_s) * PROD_W'(coef[tap]);

    conv_scale_clamp #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_scale_clamp (
        .acc    (acc),
        .result (clamp_res),
        .ovf    (clamp_ovf)
    );

    // Kernel register file: writable only while idle so a window sees a stable kernel.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (k_hit) begin
            coef[k_addr] <= k_data;
        end
    end

    // Control FSM with registered handshake/status outputs and result registers.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state       <= IDLE;
            acc         <= '0;
            tap         <= '0;
            pix_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            convolution <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        tap       <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= acc + ACC_W'(prod);
                        tap <= tap + 4'd1;
                        if (tap == LAST_TAP) begin
                            pix_ready <= 1'b0;
                            state     <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    convolution <= clamp_res;
                    overflow    <= clamp_ovf;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: directed kernel cases plus
// randomized windows compared against a plain-arithmetic reference model.
module tb_conv3x3_engine;

    logic       clk = 1'b0;
    logic       rstb;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       k_we;
    logic [3:0] k_addr;
    logic [7:0] k_data;
    logic       busy;
    logic       done;
    logic [7:0] convolution;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_coef [9];
    int m_conv;
    int m_ovf;
    int pix    [9];

    // per-window options
    int opt_max_stall;
    bit opt_stray_start;
    bit opt_stray_kwe;
    bit opt_chain;
    bit opt_skip_start;
    bit sw_we;
    int sw_addr;
    int sw_data;

    conv3x3_engine dut (
        .clk         (clk),
        .rstb        (rstb),
        .start       (start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .k_we        (k_we),
        .k_addr      (k_addr),
        .k_data      (k_data),
        .busy        (busy),
        .done        (done),
        .convolution (convolution),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int s8(input int v);
        logic signed [7:0] b;
        b = v[7:0];
        return int'(b);
    endfunction

    // Expected result: full-precision dot product, floor-divide by 16, clamp.
    task automatic model_result();
        int sum;
        int s;
        sum = 0;
        for (int i = 0; i < 9; i++) sum += pix[i] * m_coef[i];
        s = sum >>> 4;
        if (s < 0) begin
            m_conv = 0;
            m_ovf  = 1;
        end else if (s > 255) begin
            m_conv = 255;
            m_ovf  = 1;
        end else begin
            m_conv = s;
            m_ovf  = 0;
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        k_we   = 1'b1;
        k_addr = addr[3:0];
        k_data = data[7:0];
        tick();
        k_we = 1'b0;
        if (addr < 9) m_coef[addr] = s8(data);
    endtask

    task automatic set_all_coef(input int data);
        for (int i = 0; i < 9; i++) write_coef(i, data);
    endtask

    task automatic run_window();
        int prev;
        int n;
        prev = m_conv;
        if (!opt_skip_start) begin
            start = 1'b1;
            if (sw_we) begin
                k_we   = 1'b1;
                k_addr = sw_addr[3:0];
                k_data = sw_data[7:0];
            end
            tick();
            start = 1'b0;
            k_we  = 1'b0;
            if (sw_we && sw_addr < 9) m_coef[sw_addr] = s8(sw_data);
        end
        chk("busy_start", busy, 1);
        chk("ready_start", pix_ready, 1);
        for (int i = 0; i < 9; i++) begin
            n = (opt_max_stall > 0) ? int'($urandom_range(0, opt_max_stall)) : 0;
            for (int st = 0; st < n; st++) begin
                pix_valid = 1'b0;
                pix_data  = 8'($urandom);
                tick();
                chk("busy_stall", busy, 1);
                chk("ready_stall", pix_ready, 1);
            end
            pix_valid = 1'b1;
            pix_data  = 8'(pix[i]);
            if (i == 4 && opt_stray_start) start = 1'b1;
            if (i == 4 && opt_stray_kwe) begin
                k_we   = 1'b1;
                k_addr = 4'd4;
                k_data = 8'd0;
            end
            tick();
            start = 1'b0;
            k_we  = 1'b0;
            if (i < 8) chk("ready_mid", pix_ready, 1);
            chk("conv_hold", convolution, prev);
            chk("done_mid", done, 0);
        end
        pix_valid = 1'b0;
        model_result();
        chk("done_early", done, 0);
        chk("busy_fin", busy, 1);
        chk("ready_fin", pix_ready, 0);
        tick();
        chk("done_pulse", done, 1);
        chk("conv", convolution, m_conv);
        chk("ovf", overflow, m_ovf);
        chk("busy_idle", busy, 0);
        chk("ready_idle", pix_ready, 0);
        if (opt_chain) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("chain_conv", convolution, m_conv);
            chk("chain_done", done, 0);
        end else begin
            tick();
            chk("done_drop", done, 0);
            chk("conv_keep", convolution, m_conv);
        end
    endtask

    task automatic clear_opts();
        opt_max_stall   = 0;
        opt_stray_start = 1'b0;
        opt_stray_kwe   = 1'b0;
        opt_chain       = 1'b0;
        opt_skip_start  = 1'b0;
        sw_we           = 1'b0;
        sw_addr         = 0;
        sw_data         = 0;
    endtask

    task automatic ident_pixels();
        int p [9] = '{10, 20, 30, 40, 200, 60, 70, 80, 90};
        for (int i = 0; i < 9; i++) pix[i] = p[i];
    endtask

    initial begin
        rstb      = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        k_we      = 1'b0;
        k_addr    = '0;
        k_data    = '0;
        for (int i = 0; i < 9; i++) m_coef[i] = 0;
        m_conv = 0;
        m_ovf  = 0;
        clear_opts();
        tick();
        tick();
        chk("rst_conv", convolution, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", pix_ready, 0);
        rstb = 1'b0;
        tick();

        // identity kernel, back-to-back beats
        write_coef(4, 16);
        ident_pixels();
        run_window();
        chk("ident_200", convolution, 200);

        // stalls, stray start and ignored kernel write mid-window, start in done cycle
        opt_max_stall   = 2;
        opt_stray_start = 1'b1;
        opt_stray_kwe   = 1'b1;
        opt_chain       = 1'b1;
        run_window();
        chk("bp_200", convolution, 200);
        clear_opts();
        opt_skip_start = 1'b1;
        for (int i = 0; i < 9; i++) pix[i] = int'($urandom_range(0, 255));
        run_window();
        clear_opts();

        // out-of-range address in IDLE is ignored
        write_coef(12, 55);
        for (int i = 0; i < 9; i++) pix[i] = 200;
        pix[4] = 200;
        run_window();
        chk("addr12_200", convolution, 200);

        // upper clamp
        set_all_coef(16);
        for (int i = 0; i < 9; i++) pix[i] = 100;
        run_window();
        chk("hi_255", convolution, 255);
        chk("hi_ovf", overflow, 1);

        // lower clamp
        set_all_coef(8'hF0);
        for (int i = 0; i < 9; i++) pix[i] = 50;
        run_window();
        chk("lo_0", convolution, 0);
        chk("lo_ovf", overflow, 1);

        // mixed signs inside range
        set_all_coef(0);
        write_coef(0, 32);
        write_coef(8, 8'hF0);
        for (int i = 0; i < 9; i++) pix[i] = int'($urandom_range(0, 255));
        pix[0] = 100;
        pix[8] = 40;
        run_window();
        chk("mix_160", convolution, 160);
        chk("mix_ovf", overflow, 0);

        // randomized windows
        for (int w = 0; w < 16; w++) begin
            clear_opts();
            for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                write_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            sw_we         = 1'($urandom);
            sw_addr       = int'($urandom_range(0, 15));
            sw_data       = int'($urandom_range(0, 255));
            opt_max_stall = int'($urandom_range(0, 2));
            opt_stray_kwe = 1'($urandom);
            for (int i = 0; i < 9; i++) pix[i] = int'($urandom_range(0, 255));
            run_window();
        end
        clear_opts();

        // reset mid-window after 5 beats
        set_all_coef(16);
        for (int i = 0; i < 9; i++) pix[i] = 100;
        run_window();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'($urandom);
            tick();
        end
        pix_valid = 1'b0;
        #2 rstb = 1'b1;
        #1;
        chk("mrst_conv", convolution, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_ready", pix_ready, 0);
        for (int i = 0; i < 9; i++) m_coef[i] = 0;
        m_conv = 0;
        m_ovf  = 0;
        tick();
        rstb = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mrst_nodone", done, 0);
        end
        for (int i = 0; i < 9; i++) pix[i] = int'($urandom_range(1, 255));
        run_window();
        chk("zero_kernel", convolution, 0);
        chk("zero_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
